// File: rtl/timer_irq_source_pkg.sv
// Device-bus definitions shared by the bridge and the timer interrupt source:
// register offsets, CTRL field layout, mode encodings and timer FSM states.
package timer_irq_source_pkg;

    // Word offsets (byte address bits [3:2])
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    // MODE encodings; anything other than reload behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Timer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD);
    endfunction

endpackage

// File: rtl/timer_irq_source.sv
// Memory-mapped programmable down-counter driving one level interrupt line.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | stopped; waits for CTRL.EN
//   LOAD  | copies PRESET into COUNT
//   CNT   | decrements COUNT each cycle; expiry sets pend and goes to INT
//   INT   | one-shot: clear EN, back to IDLE; reload: drop pend, reload
//
// pend is set on the CNT->INT edge so irq rises P+2 edges after the EN write,
// and in reload mode the INT cycle clears it again, giving a 1-cycle pulse.
module timer_irq_source
    import timer_irq_source_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    timer_state_e state_q, state_d;
    logic         ctrl_en_q, ctrl_en_d;
    logic [1:0]   ctrl_mode_q, ctrl_mode_d;
    logic         ctrl_im_q, ctrl_im_d;
    logic [31:0]  preset_q, preset_d;
    logic [31:0]  count_q, count_d;
    logic         pend_q, pend_d;

    logic         wr_ctrl;
    logic         wr_preset;
    logic         fsm_clr_en;

    assign wr_ctrl   = we && (addr == ADDR_CTRL);
    assign wr_preset = we && (addr == ADDR_PRESET);

    // FSM next state, COUNT update and pend set/clear (set has priority)
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pend_d     = pend_q;
        fsm_clr_en = 1'b0;

        if (wr_ctrl || wr_preset) begin
            pend_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_en_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_en_q) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = 32'd0;
                    pend_d  = 1'b1;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                if (is_reload(ctrl_mode_q)) begin
                    pend_d  = 1'b0;
                    state_d = ST_LOAD;
                end else begin
                    fsm_clr_en = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register-file writes; a bus write to CTRL overrides the FSM clearing EN
    always_comb begin
        ctrl_en_d   = ctrl_en_q;
        ctrl_mode_d = ctrl_mode_q;
        ctrl_im_d   = ctrl_im_q;
        preset_d    = preset_q;

        if (wr_ctrl) begin
            ctrl_en_d   = wdata[CTRL_EN_BIT];
            ctrl_mode_d = wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
            ctrl_im_d   = wdata[CTRL_IM_BIT];
        end else if (fsm_clr_en) begin
            ctrl_en_d = 1'b0;
        end

        if (wr_preset) begin
            preset_d = wdata;
        end
    end

    // State and register flops with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ctrl_en_q   <= 1'b0;
            ctrl_mode_q <= MODE_ONESHOT;
            ctrl_im_q   <= 1'b0;
            preset_q    <= 32'd0;
            count_q     <= 32'd0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_en_q   <= ctrl_en_d;
            ctrl_mode_q <= ctrl_mode_d;
            ctrl_im_q   <= ctrl_im_d;
            preset_q    <= preset_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
        end
    end

    // Combinational read mux; reserved offset and unused CTRL bits read 0
    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_CTRL:   rdata = {28'd0, ctrl_im_q, ctrl_mode_q, ctrl_en_q};
            ADDR_PRESET: rdata = preset_q;
            ADDR_COUNT:  rdata = count_q;
            default:     rdata = 32'd0;
        endcase
    end

    // Flag AND register bit: glitch-free level for CP0 sampling
    assign irq = pend_q & ctrl_im_q;

endmodule

// File: tb/tb_timer_irq_source.sv
// Testbench for timer_irq_source: directed scenarios with fixed expected
// values plus a randomized run checked against a cycle reference model.
module tb_timer_irq_source;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_vec;
    int n_err;

    timer_irq_source dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Phases of the timer as described in prose: stopped, loading, counting,
    // just expired.
    localparam int PH_STOPPED  = 0;
    localparam int PH_LOADING  = 1;
    localparam int PH_COUNTING = 2;
    localparam int PH_EXPIRED  = 3;

    int          m_phase;
    logic        m_en;
    logic [1:0]  m_mode;
    logic        m_im;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_pend;

    function automatic logic [31:0] m_read(input logic [1:0] a);
        if (a == 2'd0) return {28'd0, m_im, m_mode, m_en};
        if (a == 2'd1) return m_preset;
        if (a == 2'd2) return m_count;
        return 32'd0;
    endfunction

    function automatic logic m_irq();
        return m_pend & m_im;
    endfunction

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_step();
        int          nx_phase;
        logic        nx_en, nx_im, nx_pend;
        logic [1:0]  nx_mode;
        logic [31:0] nx_preset, nx_count;
        logic        expired_now, reload;
        logic        ctrl_written, clears_pend;
        if (reset) begin
            m_phase = PH_STOPPED; m_en = 0; m_mode = 0; m_im = 0;
            m_preset = 0; m_count = 0; m_pend = 0;
            return;
        end
        ctrl_written = we && (addr == 2'd0);
        clears_pend  = we && (addr == 2'd0 || addr == 2'd1);
        reload       = (m_mode == 2'b01);
        nx_phase = m_phase; nx_count = m_count; expired_now = 0;
        nx_en = m_en; nx_mode = m_mode; nx_im = m_im; nx_preset = m_preset;
        nx_pend = m_pend;

        if (m_phase == PH_STOPPED && m_en) nx_phase = PH_LOADING;
        if (m_phase == PH_LOADING) begin
            nx_count = m_preset;
            nx_phase = PH_COUNTING;
        end
        if (m_phase == PH_COUNTING) begin
            if (!m_en) nx_phase = PH_STOPPED;
            else if (m_count <= 1) begin
                nx_count = 0; nx_phase = PH_EXPIRED; expired_now = 1;
            end else nx_count = m_count - 1;
        end
        if (m_phase == PH_EXPIRED) begin
            nx_phase = reload ? PH_LOADING : PH_STOPPED;
            if (!reload && !ctrl_written) nx_en = 0;
        end

        if (ctrl_written) begin
            nx_en = wdata[0]; nx_mode = wdata[2:1]; nx_im = wdata[3];
        end
        if (we && addr == 2'd1) nx_preset = wdata;

        if (expired_now) nx_pend = 1;
        else if (clears_pend || (m_phase == PH_EXPIRED && reload)) nx_pend = 0;

        m_phase = nx_phase; m_en = nx_en; m_mode = nx_mode; m_im = nx_im;
        m_preset = nx_preset; m_count = nx_count; m_pend = nx_pend;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        cyc();
        we = 1'b0; wdata = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [1:0] a;
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            addr = a; #1;
            n_vec++;
            if (rdata !== 32'd0) begin
                n_err++;
                $display("FAIL reset_read addr=%0d got=%h exp=%h", i, rdata, 32'd0);
            end
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] exp_cnt;
        logic        exp_irq;
        do_reset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        addr = 2'd2;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            exp_irq = (k >= 7);
            n_vec++;
            if (irq !== exp_irq) begin
                n_err++;
                $display("FAIL oneshot_irq k=%0d got=%b exp=%b", k, irq, exp_irq);
            end
            if (k >= 2 && k <= 7) begin
                exp_cnt = 32'(7 - k);
                n_vec++;
                if (rdata !== exp_cnt) begin
                    n_err++;
                    $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, rdata, exp_cnt);
                end
            end
        end
        addr = 2'd0; #1;
        n_vec++;
        if (rdata !== 32'h8) begin
            n_err++;
            $display("FAIL oneshot_ctrl got=%h exp=%h", rdata, 32'h8);
        end
        wr(2'd1, 32'd5);
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (irq !== 1'b0) begin
                n_err++;
                $display("FAIL oneshot_clear k=%0d got=%b exp=0", k, irq);
            end
            cyc();
        end
    endtask

    task automatic test_auto_reload();
        logic exp_irq;
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 25; k++) begin
            cyc();
            exp_irq = (k >= 5) && (((k - 5) % 5) == 0);
            n_vec++;
            if (irq !== exp_irq) begin
                n_err++;
                $display("FAIL reload_irq k=%0d got=%b exp=%b", k, irq, exp_irq);
            end
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_mask();
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            n_vec++;
            if (irq !== 1'b0) begin
                n_err++;
                $display("FAIL mask_irq k=%0d got=%b exp=0", k, irq);
            end
        end
        wr(2'd0, 32'h8);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (irq !== 1'b0 || m_irq() !== 1'b0) begin
                n_err++;
                $display("FAIL mask_unmask k=%0d got=%b exp=0", k, irq);
            end
            cyc();
        end
    endtask

    task automatic test_mid_operation();
        logic [1:0] a;
        do_reset();
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) cyc();
        wr(2'd0, 32'h0);
        addr = 2'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++;
            if (rdata !== 32'd15 || m_count !== 32'd15) begin
                n_err++;
                $display("FAIL freeze_count k=%0d got=%0d exp=%0d", k, rdata, 32'd15);
            end
            cyc();
        end
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 4; k++) cyc();
        wr(2'd1, 32'd9);
        addr = 2'd2; #1;
        n_vec++;
        if (rdata !== 32'd17) begin
            n_err++;
            $display("FAIL preset_during_cnt got=%0d exp=%0d", rdata, 32'd17);
        end
        cyc();
        n_vec++;
        if (rdata !== 32'd16) begin
            n_err++;
            $display("FAIL preset_during_cnt2 got=%0d exp=%0d", rdata, 32'd16);
        end
        addr = 2'd1; #1;
        n_vec++;
        if (rdata !== 32'd9) begin
            n_err++;
            $display("FAIL preset_read got=%0d exp=%0d", rdata, 32'd9);
        end
        wr(2'd0, 32'h0);
        cyc();
        wr(2'd0, 32'h1);
        cyc(); cyc();
        addr = 2'd2; #1;
        n_vec++;
        if (rdata !== 32'd9) begin
            n_err++;
            $display("FAIL preset_next_load got=%0d exp=%0d", rdata, 32'd9);
        end
        cyc();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            addr = a; #1;
            n_vec++;
            if (rdata !== 32'd0) begin
                n_err++;
                $display("FAIL midreset_read addr=%0d got=%h exp=0", i, rdata);
            end
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_ignored_writes();
        do_reset();
        wr(2'd1, 32'd7);
        wr(2'd0, 32'h1);
        cyc(); cyc(); cyc();
        wr(2'd0, 32'h0);
        cyc();
        wr(2'd2, 32'hDEAD);
        addr = 2'd2; #1;
        n_vec++;
        if (rdata !== 32'd5 || m_count !== 32'd5) begin
            n_err++;
            $display("FAIL count_write_ignored got=%h exp=%h", rdata, 32'd5);
        end
        wr(2'd3, 32'hFFFF_FFFF);
        addr = 2'd3; #1;
        n_vec++;
        if (rdata !== 32'd0) begin
            n_err++;
            $display("FAIL rsvd_read got=%h exp=0", rdata);
        end
        wr(2'd0, 32'hFFFF_FFF8);
        addr = 2'd0; #1;
        n_vec++;
        if (rdata !== 32'h8) begin
            n_err++;
            $display("FAIL ctrl_upper_bits got=%h exp=%h", rdata, 32'h8);
        end
        addr = 2'd2; #1;
        n_vec++;
        if (rdata !== 32'd5) begin
            n_err++;
            $display("FAIL count_after_writes got=%h exp=%h", rdata, 32'd5);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        cyc(); cyc(); cyc();
        wr(2'd1, 32'd2);
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL set_beats_clear got=%b exp=1", irq);
        end
        wr(2'd0, 32'h9);
        addr = 2'd0; #1;
        n_vec++;
        if (rdata !== 32'h9) begin
            n_err++;
            $display("FAIL bus_en_wins got=%h exp=%h", rdata, 32'h9);
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL ctrl_write_clears got=%b exp=0", irq);
        end
        for (int k = 6; k <= 9; k++) begin
            cyc();
            n_vec++;
            if (irq !== (k == 9)) begin
                n_err++;
                $display("FAIL rearm_irq k=%0d got=%b exp=%b", k, irq, (k == 9));
            end
        end
    endtask

    task automatic test_random();
        int          op;
        logic [31:0] d;
        logic [31:0] exp_rd;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            op = $urandom_range(0, 39);
            d  = $urandom;
            if (op == 0) begin
                reset = 1'b1; addr = 2'($urandom_range(0, 3));
                cyc();
                reset = 1'b0;
            end else if (op <= 4) begin
                d[0] = ($urandom_range(0, 3) != 0);
                wr(2'd0, d);
            end else if (op <= 7) begin
                wr(2'd1, 32'($urandom_range(0, 6)));
            end else if (op == 8) begin
                wr(2'd2, d);
            end else if (op == 9) begin
                wr(2'd3, d);
            end else begin
                addr = 2'($urandom_range(0, 3));
                cyc();
            end
            exp_rd = m_read(addr);
            n_vec++;
            if (rdata !== exp_rd) begin
                n_err++;
                $display("FAIL rand_rdata n=%0d addr=%0d got=%h exp=%h", n, addr, rdata, exp_rd);
            end
            n_vec++;
            if (irq !== m_irq()) begin
                n_err++;
                $display("FAIL rand_irq n=%0d got=%b exp=%b", n, irq, m_irq());
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        m_phase = PH_STOPPED; m_en = 0; m_mode = 0; m_im = 0;
        m_preset = 0; m_count = 0; m_pend = 0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_mask();
        test_mid_operation();
        test_ignored_writes();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
